// File: rtl/opcode_issue_queue.sv
// opcode_issue_queue
//   Issue stage in front of a combinational ALU. Operand packets {op, a, b}
//   are buffered in a DEPTH-entry FIFO. The FIFO head drives the ALU, and the
//   ALU result is captured into a registered, valid/ready output. Divide or
//   modulo by zero and undefined opcodes are flagged (res_err) and counted.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       packet handshake (in_ready = !full)
//   in_op, in_a, in_b       packet fields
//   alu_op, alu_a, alu_b    FIFO head to the ALU (stale when count==0)
//   alu_d                   ALU result, combinational from alu_op/a/b
//   res_valid/res_ready     result handshake
//   res_data, res_op, res_err  registered result, its opcode, trap flag
//   count                   FIFO occupancy
//   err_cnt                 saturating count of trapped results issued
module opcode_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int DW    = 12,
  parameter int RW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_op,
  input  logic [DW-1:0]            in_a,
  input  logic [DW-1:0]            in_b,
  output logic [OPW-1:0]           alu_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  input  logic [RW-1:0]            alu_d,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RW-1:0]            res_data,
  output logic [OPW-1:0]           res_op,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } pkt_t;

  pkt_t          mem [DEPTH];
  pkt_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, issue, div0, undef, trap;

  // in_ready depends on registered occupancy only: a pop in the same cycle
  // does not open a slot for a push into a full queue.
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign issue    = (count != '0) && (!res_valid || res_ready);

  assign head   = mem[rd_ptr];
  assign alu_op = head.op;
  assign alu_a  = head.a;
  assign alu_b  = head.b;

  assign div0  = ((alu_op == OPW'(3)) || (alu_op == OPW'(4))) && (alu_b == '0);
  assign undef = (alu_op >= OPW'(5));
  assign trap  = div0 || undef;

  // Storage is not reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      if (push && !issue)      count <= count + (AW+1)'(1);
      else if (issue && !push) count <= count - (AW+1)'(1);
    end
  end

  // Result register: loads only on issue, so a stalled result never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (issue) begin
        res_valid <= 1'b1;
        res_op    <= alu_op;
        res_data  <= div0 ? '0 : alu_d;  // undefined ops pass the ALU echo through
        res_err   <= trap;
        if (trap && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/opcode_issue_queue.md
Name: opcode_issue_queue

Overview:
- Upstream issue stage for the 4-bit-op / 12-bit-operand / 32-bit-result combinational ALU.
- Buffers operand packets {op, a, b} in a small FIFO and presents the FIFO head to the ALU.
- Captures the ALU result into a registered output with a valid/ready handshake.
- Traps divide/modulo by zero and undefined opcodes before they reach the consumer.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- OPW, 4, opcode width
- DW, 12, operand width
- RW, 32, ALU result width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  packet offered
- in_ready  output  1  queue can accept; equals !full
- in_op  input  OPW  opcode
- in_a  input  DW  operand a
- in_b  input  DW  operand b
- alu_op  output  OPW  FIFO-head opcode to ALU
- alu_a  output  DW  FIFO-head operand a to ALU
- alu_b  output  DW  FIFO-head operand b to ALU
- alu_d  input  RW  ALU result, combinational from alu_op/alu_a/alu_b
- res_valid  output  1  result register holds data
- res_ready  input  1  consumer accepts result
- res_data  output  RW  registered result
- res_op  output  OPW  opcode that produced res_data
- res_err  output  1  result is trapped (see below)
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- err_cnt  output  8  saturating count of trapped results issued

Behaviour:
- Reset (async, rst_n=0): FIFO pointers 0, count=0, res_valid=0, res_data=0, res_op=0, res_err=0, err_cnt=0.
- During and after reset, in_ready=1 (FIFO empty).
- Reset mid-operation discards all queued packets and any pending result. No output glitches other than going to reset values.
- push = in_valid && in_ready. The packet is written at the FIFO tail on the clock edge.
- alu_op/alu_a/alu_b = FIFO head, combinational from storage. When count=0 they show the stale head entry; the consumer must ignore them.
- issue = (count != 0) && (!res_valid || res_ready). Evaluated per cycle.
- On issue, at the clock edge:
  - pop the head;
  - res_valid <= 1;
  - res_op <= alu_op.
- Trap rules on issue:
  - Divide/modulo by zero (alu_op = 4'b0011 or 4'b0100, alu_b = 0): res_data <= 0, res_err <= 1.
  - Undefined opcode (alu_op >= 4'b0101): res_data <= alu_d unchanged (ALU echoes the opcode), res_err <= 1.
  - Otherwise: res_data <= alu_d, res_err <= 0.
- err_cnt increments on every issue with a trap. It saturates at 255 and does not wrap.
- If res_valid && res_ready && !issue, then res_valid <= 0. res_data, res_op and res_err hold their last values.
- res_data/res_op/res_err are stable while res_valid && !res_ready. The handshake must never drop or alter a pending result.
- Occupancy:
  - push && !issue: count+1
  - issue && !push: count-1
  - both: count unchanged (legal whenever count < DEPTH)
- Full (count=DEPTH): in_ready=0 and in_valid is ignored. Because in_ready is registered-state only, there is no same-cycle pop bypass.
- Empty (count=0): no issue. A push into an empty FIFO is not forwarded combinationally.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Latency:
  - A packet pushed at edge k into an empty queue with an idle output reaches the head at k+1 and issues at edge k+1.
  - res_valid is therefore high after edge k+1: 2 cycles from in_valid to res_valid.
- Throughput: 1 result/cycle when res_ready is held high.
- Order: results leave strictly in push order.

Test Plan:
- Reset, then push {op=0,a=100,b=23} with res_ready=1 -> res_valid high 2 cycles later, res_data=123, res_op=0, res_err=0, count back to 0.
- Push op=2,a=4095,b=4095 then op=3,a=100,b=7 then op=4,a=100,b=7, res_ready=1 -> res_data sequence 16769025, 14, 2 on consecutive cycles, in order.
- Push op=3,a=50,b=0 and op=9,a=1,b=1 -> first result res_data=0 with res_err=1; second res_data=9 with res_err=1; err_cnt=2.
- Hold res_ready=0, push 5 packets -> 1 in result register, count=4, in_ready=0, 6th in_valid ignored. Release res_ready -> 5 results in order, res_data stable while stalled.
- Simultaneous push and issue at count=2 for 10 cycles -> count stays 2, no lost or duplicated results.
- Assert rst_n=0 asynchronously mid-stream with count=3, res_valid=1 -> all outputs at reset values immediately, in_ready=1, no stale results after release.
- 300 consecutive trapped ops (op=4, b=0) -> err_cnt saturates at 255.
